// File: rtl/nf_stats_pkg.sv
// Shared counter indices and statistics-vector field offsets for the 10G port stats block.
// Latency: n/a (constants only). Backpressure: n/a.
// Saturation is selected per build with NF_STATS_SATURATE_EN.
package nf_stats_pkg;

    localparam int CNT_RX_GOOD  = 0;
    localparam int CNT_RX_BAD   = 1;
    localparam int CNT_RX_BYTES = 2;
    localparam int CNT_TX_PKTS  = 3;
    localparam int CNT_TX_BYTES = 4;
    localparam int CNT_LINK_CHG = 5;
    localparam int NUM_CNTS     = 6;

    localparam int STAT_GOOD_BIT  = 0;
    localparam int STAT_BAD_BIT   = 1;
    localparam int STAT_BYTES_LSB = 5;
    localparam int STAT_BYTES_MSB = 18;

    localparam int RX_VEC_W = 30;
    localparam int TX_VEC_W = 26;

endpackage

// File: rtl/nf_stats_counter.sv
// One statistics counter: add on inc_en, zero or load-with-increment on clr; NF_STATS_SATURATE_EN clamps.
// Latency: value updates one cycle after inc_en/clr.
// Backpressure: none, every increment is accepted.
module nf_stats_counter #(
    parameter int W = 32
) (
    input  logic         axis_aclk,
    input  logic         axis_aresetn,
    input  logic         inc_en,
    input  logic [W-1:0] inc_amt,
    input  logic         clr,
    input  logic         load_inc_on_clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_nxt;

`ifdef NF_STATS_SATURATE_EN
    logic [W:0] sum;
    assign sum     = {1'b0, cnt_q} + {1'b0, inc_amt};
    assign cnt_nxt = sum[W] ? '1 : sum[W-1:0];
`else
    assign cnt_nxt = cnt_q + inc_amt;
`endif

    // A clearing read keeps a same-cycle event so nothing is lost.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= (load_inc_on_clr && inc_en) ? inc_amt : '0;
        end else if (inc_en) begin
            cnt_q <= cnt_nxt;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/nf_10g_port_stats_aggregator.sv
// Per-port rx/tx/link counters and sticky link-change irqs for C_NUM_PORTS 10G MACs (NF_STATS_SATURATE_EN: saturating counters).
// Latency: counters update 1 cycle after strobe; rd_valid/rd_data 1 cycle after rd_req.
// Backpressure: none, strobes and rd_req are accepted every cycle.
module nf_10g_port_stats_aggregator
    import nf_stats_pkg::*;
#(
    parameter int C_NUM_PORTS    = 4,
    parameter int C_CNT_WIDTH    = 32,
    parameter int C_STATUS_WIDTH = 8
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_aresetn,
    input  logic [C_NUM_PORTS-1:0]                rx_stats_valid,
    input  logic [RX_VEC_W*C_NUM_PORTS-1:0]       rx_stats_vector,
    input  logic [C_NUM_PORTS-1:0]                tx_stats_valid,
    input  logic [TX_VEC_W*C_NUM_PORTS-1:0]       tx_stats_vector,
    input  logic [C_STATUS_WIDTH*C_NUM_PORTS-1:0] pcspma_status,
    input  logic                                  rd_req,
    input  logic [2:0]                            rd_port,
    input  logic [2:0]                            rd_idx,
    input  logic                                  rd_clear,
    input  logic                                  clear_all,
    input  logic [C_NUM_PORTS-1:0]                irq_clr,
    output logic                                  rd_valid,
    output logic [C_CNT_WIDTH-1:0]                rd_data,
    output logic [C_NUM_PORTS-1:0]                link_up,
    output logic [C_NUM_PORTS-1:0]                link_irq
);

    localparam logic [C_CNT_WIDTH-1:0] ONE = C_CNT_WIDTH'(1);

    logic [C_CNT_WIDTH-1:0] cnt_val [C_NUM_PORTS][NUM_CNTS];
    logic [C_NUM_PORTS-1:0] link_stat;
    logic [C_NUM_PORTS-1:0] link_chg;
    logic [C_CNT_WIDTH-1:0] rd_sel;
    logic                   unused_bits;

    // Only the good/bad/bytes fields and status bit 0 carry meaning here.
    assign unused_bits = ^{rx_stats_vector, tx_stats_vector, pcspma_status};

    for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
        logic [RX_VEC_W-1:0]    rx_v;
        logic [TX_VEC_W-1:0]    tx_v;
        logic                   rx_good;
        logic                   rx_bad;
        logic                   tx_ok;
        logic [NUM_CNTS-1:0]    en;
        logic [C_CNT_WIDTH-1:0] amt [NUM_CNTS];

        assign rx_v      = rx_stats_vector[p*RX_VEC_W +: RX_VEC_W];
        assign tx_v      = tx_stats_vector[p*TX_VEC_W +: TX_VEC_W];
        assign rx_bad    = rx_stats_valid[p] & rx_v[STAT_BAD_BIT];
        assign rx_good   = rx_stats_valid[p] & rx_v[STAT_GOOD_BIT] & ~rx_v[STAT_BAD_BIT];
        assign tx_ok     = tx_stats_valid[p] & tx_v[STAT_GOOD_BIT];
        assign link_stat[p] = pcspma_status[p*C_STATUS_WIDTH];
        assign link_chg[p]  = link_stat[p] ^ link_up[p];

        assign en[CNT_RX_GOOD]  = rx_good;
        assign en[CNT_RX_BAD]   = rx_bad;
        assign en[CNT_RX_BYTES] = rx_good;
        assign en[CNT_TX_PKTS]  = tx_ok;
        assign en[CNT_TX_BYTES] = tx_ok;
        assign en[CNT_LINK_CHG] = link_chg[p];

        assign amt[CNT_RX_GOOD]  = ONE;
        assign amt[CNT_RX_BAD]   = ONE;
        assign amt[CNT_RX_BYTES] = C_CNT_WIDTH'(rx_v[STAT_BYTES_MSB:STAT_BYTES_LSB]);
        assign amt[CNT_TX_PKTS]  = ONE;
        assign amt[CNT_TX_BYTES] = C_CNT_WIDTH'(tx_v[STAT_BYTES_MSB:STAT_BYTES_LSB]);
        assign amt[CNT_LINK_CHG] = ONE;

        for (genvar c = 0; c < NUM_CNTS; c++) begin : g_cnt
            logic rd_hit;
            assign rd_hit = rd_req && (rd_port == 3'(p)) && (rd_idx == 3'(c));

            // clear_all overrides a clearing read and drops same-cycle events.
            nf_stats_counter #(.W(C_CNT_WIDTH)) u_cnt (
                .axis_aclk       (axis_aclk),
                .axis_aresetn    (axis_aresetn),
                .inc_en          (en[c]),
                .inc_amt         (amt[c]),
                .clr             (clear_all | (rd_hit & rd_clear)),
                .load_inc_on_clr (~clear_all),
                .cnt             (cnt_val[p][c])
            );
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            for (int c = 0; c < NUM_CNTS; c++) begin
                if (rd_port == 3'(p) && rd_idx == 3'(c)) begin
                    rd_sel = cnt_val[p][c];
                end
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            link_up  <= '0;
            link_irq <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rd_sel;
            end
            link_up  <= link_stat;
            link_irq <= link_chg | (link_irq & ~irq_clr);
        end
    end

endmodule

// File: tb/tb_nf_10g_port_stats_aggregator.sv
// Directed bench for nf_10g_port_stats_aggregator; read expectations queued at issue, checked at rd_valid.
// Expected saturation behaviour follows NF_STATS_SATURATE_EN.
module tb_nf_10g_port_stats_aggregator;

    localparam int NP = 4;
    localparam int CW = 32;
    localparam int SW = 8;

    logic              clk = 1'b0;
    logic              axis_aresetn;
    logic [NP-1:0]     rx_stats_valid;
    logic [30*NP-1:0]  rx_stats_vector;
    logic [NP-1:0]     tx_stats_valid;
    logic [26*NP-1:0]  tx_stats_vector;
    logic [SW*NP-1:0]  pcspma_status;
    logic              rd_req;
    logic [2:0]        rd_port;
    logic [2:0]        rd_idx;
    logic              rd_clear;
    logic              clear_all;
    logic [NP-1:0]     irq_clr;
    logic              rd_valid;
    logic [CW-1:0]     rd_data;
    logic [NP-1:0]     link_up;
    logic [NP-1:0]     link_irq;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];
    string         tag_q[$];

    always #5 clk = ~clk;

    nf_10g_port_stats_aggregator #(
        .C_NUM_PORTS    (NP),
        .C_CNT_WIDTH    (CW),
        .C_STATUS_WIDTH (SW)
    ) dut (
        .axis_aclk       (clk),
        .axis_aresetn    (axis_aresetn),
        .rx_stats_valid  (rx_stats_valid),
        .rx_stats_vector (rx_stats_vector),
        .tx_stats_valid  (tx_stats_valid),
        .tx_stats_vector (tx_stats_vector),
        .pcspma_status   (pcspma_status),
        .rd_req          (rd_req),
        .rd_port         (rd_port),
        .rd_idx          (rd_idx),
        .rd_clear        (rd_clear),
        .clear_all       (clear_all),
        .irq_clr         (irq_clr),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .link_up         (link_up),
        .link_irq        (link_irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx(input int p, input logic good, input logic bad, input logic [13:0] bytes);
        logic [29:0] v;
        v = '0;
        v[0] = good;
        v[1] = bad;
        v[18:5] = bytes;
        rx_stats_vector[30*p +: 30] = v;
        rx_stats_valid[p] = 1'b1;
    endtask

    task automatic tx(input int p, input logic ok, input logic [13:0] bytes);
        logic [25:0] v;
        v = '0;
        v[0] = ok;
        v[18:5] = bytes;
        tx_stats_vector[26*p +: 26] = v;
        tx_stats_valid[p] = 1'b1;
    endtask

    task automatic rd(input int p, input int i, input logic clr, input logic [CW-1:0] exp, input string tag);
        rd_req   = 1'b1;
        rd_port  = 3'(p);
        rd_idx   = 3'(i);
        rd_clear = clr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // One clock: check read response 1ns after the edge, then drop strobes on the falling edge.
    task automatic tick();
        logic issued;
        issued = rd_req;
        @(posedge clk);
        #1;
        if (issued) begin
            check("rd_valid", {63'b0, rd_valid}, 64'd1);
            if (exp_q.size() > 0) begin
                check(tag_q.pop_front(), {32'b0, rd_data}, {32'b0, exp_q.pop_front()});
            end
        end else begin
            check("rd_valid_idle", {63'b0, rd_valid}, 64'd0);
        end
        @(negedge clk);
        rx_stats_valid  = '0;
        tx_stats_valid  = '0;
        rx_stats_vector = '0;
        tx_stats_vector = '0;
        rd_req          = 1'b0;
        rd_clear        = 1'b0;
        clear_all       = 1'b0;
        irq_clr         = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] sat_exp;
        axis_aresetn    = 1'b0;
        rx_stats_valid  = '0;
        rx_stats_vector = '0;
        tx_stats_valid  = '0;
        tx_stats_vector = '0;
        pcspma_status   = '0;
        rd_req          = 1'b0;
        rd_port         = '0;
        rd_idx          = '0;
        rd_clear        = 1'b0;
        clear_all       = 1'b0;
        irq_clr         = '0;

        repeat (3) @(negedge clk);
        check("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
        check("rst_rd_data", {32'b0, rd_data}, 64'd0);
        check("rst_link_up", {60'b0, link_up}, 64'd0);
        check("rst_link_irq", {60'b0, link_irq}, 64'd0);
        axis_aresetn = 1'b1;
        @(negedge clk);

        rd(0, 2, 1'b0, 0, "t1_p0_rx_bytes");
        tick();
        check("t1_link_irq", {60'b0, link_irq}, 64'd0);

        rx(1, 1'b1, 1'b0, 14'd64);   tick();
        rx(1, 1'b1, 1'b0, 14'd1518); tick();
        rx(1, 1'b1, 1'b0, 14'd9000); tick();
        rd(1, 0, 1'b0, 3, "t2_p1_rx_good");      tick();
        rd(1, 2, 1'b0, 10582, "t2_p1_rx_bytes"); tick();
        rd(1, 1, 1'b0, 0, "t2_p1_rx_bad");       tick();

        rx(2, 1'b1, 1'b1, 14'd100); tick();
        rd(2, 1, 1'b0, 1, "t3_p2_rx_bad");   tick();
        rd(2, 0, 1'b0, 0, "t3_p2_rx_good");  tick();
        rd(2, 2, 1'b0, 0, "t3_p2_rx_bytes"); tick();

        repeat (7) begin
            tx(0, 1'b1, 14'd100);
            tick();
        end
        tx(0, 1'b0, 14'd50); tick();
        tx(0, 1'b1, 14'd100);
        rd(0, 3, 1'b1, 7, "t4_clr_read");
        tick();
        rd(0, 3, 1'b0, 1, "t4_after_clr");  tick();
        rd(0, 4, 1'b0, 800, "t4_tx_bytes"); tick();

        pcspma_status[3*SW] = 1'b1; tick();
        check("t5_link_up_rise", {60'b0, link_up}, 64'h8);
        pcspma_status[3*SW] = 1'b0; tick();
        check("t5_link_up_fall", {60'b0, link_up}, 64'h0);
        rd(3, 5, 1'b0, 2, "t5_link_changes"); tick();
        check("t5_link_irq", {60'b0, link_irq}, 64'h8);
        pcspma_status[3*SW] = 1'b1;
        irq_clr[3] = 1'b1;
        tick();
        check("t5_set_beats_clr", {60'b0, link_irq}, 64'h8);
        irq_clr[3] = 1'b1; tick();
        check("t5_irq_cleared", {60'b0, link_irq}, 64'h0);
        rd(3, 5, 1'b0, 3, "t5_link_changes3"); tick();

        rd(5, 0, 1'b0, 0, "bad_port"); tick();
        rd(1, 6, 1'b0, 0, "bad_idx");  tick();

        force dut.g_port[2].g_cnt[4].u_cnt.cnt_q = '1;
        #1;
        release dut.g_port[2].g_cnt[4].u_cnt.cnt_q;
        rd(2, 4, 1'b0, '1, "t6_preload"); tick();
        tx(2, 1'b1, 14'd64); tick();
`ifdef NF_STATS_SATURATE_EN
        sat_exp = '1;
`else
        sat_exp = 32'd63;
`endif
        rd(2, 4, 1'b0, sat_exp, "t6_overflow"); tick();
        clear_all = 1'b1;
        tx(2, 1'b1, 14'd10);
        rd(2, 4, 1'b1, sat_exp, "t6_preclear"); tick();
        rd(2, 4, 1'b0, 0, "t6_cleared");       tick();
        rd(2, 3, 1'b0, 0, "t6_tx_pkts_drop");  tick();
        rd(1, 2, 1'b0, 0, "t6_p1_rx_bytes");   tick();

        rd_req  = 1'b1;
        rd_port = 3'd0;
        rd_idx  = 3'd0;
        @(posedge clk);
        #1;
        check("rst_mid_before", {63'b0, rd_valid}, 64'd1);
        axis_aresetn = 1'b0;
        #1;
        check("rst_mid_valid", {63'b0, rd_valid}, 64'd0);
        @(negedge clk);
        rd_req = 1'b0;
        axis_aresetn = 1'b1;
        tick();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
